// File: rtl/cory_pkg.sv
// Shared definitions for the cory SRAM adapters: active-low enable levels
// and a constant-evaluable ceil(log2) helper used to size counters.
package cory_pkg;

    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sram_ro_fifo.sv
// Small synchronous FIFO holding SRAM return words until the sink takes them.
// Depth C is arbitrary (not restricted to a power of two); pointers wrap at C.
// The head word reads as zero while the FIFO is empty so the output bus is
// clean after reset.
module sram_ro_fifo
    import cory_pkg::*;
#(
    parameter  int D  = 8,
    parameter  int C  = 1,
    localparam int CW = clog2(C + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [D-1:0]  wdata,
    output logic [D-1:0]  rdata,
    output logic [CW-1:0] cnt,
    output logic          empty,
    output logic          full
);

    localparam int PW = (C > 1) ? clog2(C) : 1;

    logic [D-1:0]  mem [0:(1 << PW) - 1];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(C - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage array; written on every push, contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep cnt
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign empty = (cnt == '0);
    assign full  = (cnt == CW'(C));
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/sram_ro.sv
// Read-only SRAM adapter: forwards requester reads to a one-cycle-latency
// SRAM and turns the returned words into a valid/ready stream. A read is only
// accepted when a buffer slot is guaranteed for its data, counting the word
// already in flight and any word leaving this cycle.
// Optional macro CORY_SRAM_RO_CHECK_EN enables simulation-only protocol checks.
module sram_ro
    import cory_pkg::*;
#(
    parameter int A = 8,
    parameter int D = 8,
    parameter int C = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_s_cen,
    input  logic         i_s_oen,
    input  logic [A-1:0] i_s_addr,
    output logic         o_s_r,
    output logic         o_z_cen,
    output logic         o_z_oen,
    output logic [A-1:0] o_z_addr,
    input  logic [D-1:0] i_z_rdata,
    input  logic         i_z_r,
    output logic         o_d_v,
    output logic [D-1:0] o_d_d,
    input  logic         i_d_r
);

    localparam int CW = clog2(C + 1);
    localparam int OW = CW + 1;

    logic          accept;
    logic          inflight;
    logic          pop;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_cnt;
    logic [OW-1:0] occ;

    assign accept   = (i_s_cen == CEN_ON) & o_s_r;
    assign o_z_cen  = accept ? CEN_ON : CEN_OFF;
    assign o_z_addr = i_s_addr;
    assign o_z_oen  = i_s_oen;

    assign pop   = o_d_v & i_d_r;
    assign o_d_v = !fifo_empty;
    assign occ   = {1'b0, fifo_cnt} + OW'(inflight);
    assign o_s_r = !reset & i_z_r &
                   ((occ < OW'(C)) | (pop & (occ <= OW'(C))));

    // Marks the cycle in which the SRAM drives data for the last accepted read
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 1'b0;
        end else begin
            inflight <= accept;
        end
    end

    sram_ro_fifo #(
        .D (D),
        .C (C)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inflight),
        .pop   (pop),
        .wdata (i_z_rdata),
        .rdata (o_d_d),
        .cnt   (fifo_cnt),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef CORY_SRAM_RO_CHECK_EN
    logic         prev_hold;
    logic [D-1:0] prev_d;

    // Remember whether the output was stalled last cycle and what it showed
    always @(posedge clk) begin
        prev_hold <= !reset & o_d_v & !i_d_r;
        prev_d    <= o_d_d;
    end

    // Protocol checks; each reports and stops the simulation shortly after
    always @(posedge clk) begin
        if (!reset) begin
            if ((i_s_oen == CEN_ON) && !inflight) begin
                $display("ERROR:%m: oen without read at %0t", $time);
                #100 $finish;
            end
            if (inflight && fifo_full) begin
                $display("ERROR:%m: push while full at %0t", $time);
                #100 $finish;
            end
            if (prev_hold && (o_d_d !== prev_d)) begin
                $display("ERROR:%m: o_d_d changed while stalled at %0t", $time);
                #100 $finish;
            end
        end
    end
`else
    wire unused_fifo_full = fifo_full;
`endif

endmodule

// File: tb/tb_sram_ro.sv
// Directed bench for sram_ro: one instance with C=1 (index 0) and one with
// C=2 (index 1). A behavioural SRAM returns sram_mem[addr] one cycle after the
// address; expected words are queued when a read is driven and compared when
// the DUT hands them out.
module tb_sram_ro;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      s_cen;
    logic [1:0]      s_oen;
    logic [1:0][7:0] s_addr;
    logic [1:0]      s_r;
    logic [1:0]      z_cen;
    logic [1:0]      z_oen;
    logic [1:0][7:0] z_addr;
    logic [1:0][7:0] z_rdata;
    logic [1:0]      z_r;
    logic [1:0]      d_v;
    logic [1:0][7:0] d_d;
    logic [1:0]      d_r;

    logic [7:0] sram_mem [256];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    sram_ro #(.A(8), .D(8), .C(1)) u_dut_c1 (
        .clk       (clk),
        .reset     (reset),
        .i_s_cen   (s_cen[0]),
        .i_s_oen   (s_oen[0]),
        .i_s_addr  (s_addr[0]),
        .o_s_r     (s_r[0]),
        .o_z_cen   (z_cen[0]),
        .o_z_oen   (z_oen[0]),
        .o_z_addr  (z_addr[0]),
        .i_z_rdata (z_rdata[0]),
        .i_z_r     (z_r[0]),
        .o_d_v     (d_v[0]),
        .o_d_d     (d_d[0]),
        .i_d_r     (d_r[0])
    );

    sram_ro #(.A(8), .D(8), .C(2)) u_dut_c2 (
        .clk       (clk),
        .reset     (reset),
        .i_s_cen   (s_cen[1]),
        .i_s_oen   (s_oen[1]),
        .i_s_addr  (s_addr[1]),
        .o_s_r     (s_r[1]),
        .o_z_cen   (z_cen[1]),
        .o_z_oen   (z_oen[1]),
        .o_z_addr  (z_addr[1]),
        .i_z_rdata (z_rdata[1]),
        .i_z_r     (z_r[1]),
        .o_d_v     (d_v[1]),
        .o_d_d     (d_d[1]),
        .i_d_r     (d_r[1])
    );

    // Behavioural synchronous SRAM: data for the address seen at an edge
    always @(posedge clk) begin
        z_rdata[0] <= sram_mem[z_addr[0]];
        z_rdata[1] <= sram_mem[z_addr[1]];
    end

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int k, input logic cen, input logic oen,
                                  input logic [7:0] addr);
        s_cen[k]  = cen;
        s_oen[k]  = oen;
        s_addr[k] = addr;
        #1;
    endtask

    task automatic drain(input int k);
        for (int i = 0; i < 20; i++) begin
            if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) break;
            tick();
        end
        check_output($sformatf("drain%0d", k),
                     k == 0 ? exp_q0.size() : exp_q1.size(), 0);
    endtask

    // Scoreboard: every handshake on either output must match the next word
    always @(negedge clk) begin
        if (!reset) begin
            if (d_v[0] && d_r[0]) begin
                if (exp_q0.size() == 0) check_output("c1_extra_word", d_v[0], 0);
                else check_output("c1_word", d_d[0], exp_q0.pop_front());
            end
            if (d_v[1] && d_r[1]) begin
                if (exp_q1.size() == 0) check_output("c2_extra_word", d_v[1], 0);
                else check_output("c2_word", d_d[1], exp_q1.pop_front());
            end
        end
    end

    initial begin
        $display("[TB] sram_ro directed run");
        for (int i = 0; i < 256; i++) sram_mem[i] = 8'(i) ^ 8'h3C;
        reset  = 1'b1;
        s_cen  = 2'b11;
        s_oen  = 2'b11;
        s_addr = '0;
        z_r    = 2'b11;
        d_r    = 2'b11;

        // Reset state; oen passes through even in reset
        tick();
        tick();
        apply_stimulus(0, 1'b1, 1'b0, 8'h00);
        check_output("rst_oen_pass", z_oen[0], 0);
        check_output("rst_sr_c1", s_r[0], 0);
        check_output("rst_sr_c2", s_r[1], 0);
        check_output("rst_zcen", z_cen[0], 1);
        check_output("rst_dv", d_v[0], 0);
        check_output("rst_dd", d_d[0], 0);
        apply_stimulus(0, 1'b1, 1'b1, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        check_output("idle_sr", s_r[0], 1);
        check_output("idle_dv", d_v[0], 0);
        check_output("idle_zcen", z_cen[0], 1);

        // C=1 single read of 0x05 returning 0xA5
        sram_mem[8'h05] = 8'hA5;
        apply_stimulus(0, 1'b0, 1'b1, 8'h05);
        check_output("c1_accept_sr", s_r[0], 1);
        check_output("c1_accept_zcen", z_cen[0], 0);
        check_output("c1_accept_addr", z_addr[0], 8'h05);
        exp_q0.push_back(8'hA5);
        tick();
        apply_stimulus(0, 1'b1, 1'b0, 8'h00);
        check_output("c1_t1_sr", s_r[0], 0);
        check_output("c1_t1_dv", d_v[0], 0);
        check_output("c1_t1_zoen", z_oen[0], 0);
        tick();
        apply_stimulus(0, 1'b1, 1'b1, 8'h00);
        check_output("c1_t2_dv", d_v[0], 1);
        check_output("c1_t2_dd", d_d[0], 8'hA5);
        check_output("c1_t2_sr", s_r[0], 1);
        tick();
        check_output("c1_t3_dv", d_v[0], 0);
        drain(0);

        // C=2 back-to-back reads 0..7
        for (int i = 0; i < 8; i++) sram_mem[i] = 8'(i) + 8'h10;
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(1, 1'b0, (i == 0), 8'(i));
            check_output($sformatf("c2_stream_sr%0d", i), s_r[1], 1);
            check_output($sformatf("c2_stream_zcen%0d", i), z_cen[1], 0);
            exp_q1.push_back(8'(i) + 8'h10);
            tick();
        end
        apply_stimulus(1, 1'b1, 1'b0, 8'h00);
        check_output("c2_stream_end_zcen", z_cen[1], 1);
        tick();
        apply_stimulus(1, 1'b1, 1'b1, 8'h00);
        drain(1);

        // C=2 with stalled sink
        sram_mem[8'h20] = 8'h55;
        sram_mem[8'h21] = 8'h66;
        d_r[1] = 1'b0;
        apply_stimulus(1, 1'b0, 1'b1, 8'h20);
        check_output("stall_acc0", s_r[1], 1);
        exp_q1.push_back(8'h55);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 8'h21);
        check_output("stall_acc1", s_r[1], 1);
        exp_q1.push_back(8'h66);
        tick();
        apply_stimulus(1, 1'b0, 1'b0, 8'h22);
        check_output("stall_block_sr", s_r[1], 0);
        check_output("stall_block_zcen", z_cen[1], 1);
        check_output("stall_head", d_d[1], 8'h55);
        tick();
        apply_stimulus(1, 1'b1, 1'b1, 8'h00);
        check_output("stall_full_sr", s_r[1], 0);
        check_output("stall_hold_a", d_d[1], 8'h55);
        tick();
        check_output("stall_hold_b", d_d[1], 8'h55);
        check_output("stall_hold_dv", d_v[1], 1);
        d_r[1] = 1'b1;
        #1;
        check_output("stall_pop_sr", s_r[1], 1);
        tick();
        check_output("stall_second", d_d[1], 8'h66);
        tick();
        check_output("stall_empty", d_v[1], 0);
        drain(1);

        // SRAM not ready blocks acceptance
        sram_mem[8'h30] = 8'h9E;
        z_r[1] = 1'b0;
        apply_stimulus(1, 1'b0, 1'b1, 8'h30);
        check_output("zr_low_sr", s_r[1], 0);
        check_output("zr_low_zcen", z_cen[1], 1);
        tick();
        check_output("zr_low_dv", d_v[1], 0);
        z_r[1] = 1'b1;
        #1;
        check_output("zr_high_sr", s_r[1], 1);
        check_output("zr_high_zcen", z_cen[1], 0);
        exp_q1.push_back(8'h9E);
        tick();
        apply_stimulus(1, 1'b1, 1'b0, 8'h00);
        tick();
        apply_stimulus(1, 1'b1, 1'b1, 8'h00);
        drain(1);

        // Reset while a read is in flight discards it
        apply_stimulus(1, 1'b0, 1'b1, 8'h40);
        check_output("rstmid_accept", s_r[1], 1);
        tick();
        reset = 1'b1;
        apply_stimulus(1, 1'b1, 1'b1, 8'h00);
        check_output("rstmid_sr", s_r[1], 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_output($sformatf("rstmid_dv%0d", i), d_v[1], 0);
            tick();
        end
        check_output("rstmid_cnt", u_dut_c2.fifo_cnt, 0);
        check_output("rstmid_inflight", u_dut_c2.inflight, 0);
        check_output("end_q1", exp_q1.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
